// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU-wide widths, PC stepping and reset constants.
// Used by the fetch buffer and its instruction FIFO.
package cpu_pkg;

    localparam int PC_W   = 32;
    localparam int INST_W = 32;

    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [INST_W-1:0] inst_t;

    localparam pc_t   PC_STEP          = 32'd4;
    localparam inst_t NOP_INST         = 32'h0000_0000;
    localparam pc_t   DEFAULT_RESET_PC = 32'h0000_0000;

    // Sequential PC advance; wraps modulo 2^PC_W by construction.
    function automatic pc_t pc_next(input pc_t pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous instruction FIFO with single-cycle flush and occupancy count.
// Head word is read combinationally so the fetch buffer can present it without a bubble.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = INST_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == FULL_COUNT);
    assign do_push   = push && !flush && !full;
    assign do_pop    = pop && !flush && !empty;
    assign count     = count_reg;
    assign head_data = mem[rd_ptr_reg];

    // DEPTH is a power of two, so the pointers wrap naturally at AW bits.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_next = count_reg + CW'(1);
            end else if (!do_push && do_pop) begin
                count_next = count_reg - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_buf.sv
// fetch_buf: credit-based instruction fetch unit feeding if_id through an in-order queue.
// Optional same-cycle bypass of an empty queue is enabled by defining FETCH_BUF_BYPASS_EN.
module fetch_buf
    import cpu_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    input  logic              out_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(DEPTH);

    logic [PC_W-1:0]   fetch_pc_reg;
    logic [PC_W-1:0]   fetch_pc_next;
    logic [PC_W-1:0]   deliver_pc_reg;
    logic [PC_W-1:0]   deliver_pc_next;
    logic [CW-1:0]     outstanding_reg;
    logic [CW-1:0]     outstanding_next;
    logic [CW-1:0]     drop_reg;
    logic [CW-1:0]     drop_next;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       credit_used;
    logic [CW-1:0]     rvalid_dec;
    logic [INST_W-1:0] fifo_head;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              grant;
    logic              rsp_drop;
    logic              rsp_live;
    logic              bypass_hit;
    logic              transfer;

    // Every granted request reserves a queue slot until its word leaves, so the queue cannot overflow.
    assign credit_used = {1'b0, outstanding_reg} + {1'b0, fifo_count};
    assign imem_req    = !rst && !redirect_valid && (credit_used < CREDIT_LIMIT);
    assign imem_addr   = fetch_pc_reg;
    assign grant       = imem_req && imem_gnt;

    assign rvalid_dec = {{(CW-1){1'b0}}, imem_rvalid};
    assign rsp_drop   = imem_rvalid && (drop_reg != '0);
    assign rsp_live   = imem_rvalid && (drop_reg == '0) && !redirect_valid && !rst;

`ifdef FETCH_BUF_BYPASS_EN
    assign bypass_hit = rsp_live && fifo_empty;
`else
    assign bypass_hit = 1'b0;
`endif

    assign out_valid = !redirect_valid && (!fifo_empty || bypass_hit);
    assign out_pc    = deliver_pc_reg;
    assign transfer  = out_valid && out_ready;
    assign fifo_pop  = transfer && !fifo_empty;
    // A bypassed word that is accepted immediately never occupies a slot.
    assign fifo_push = rsp_live && !(bypass_hit && out_ready);

    always_comb begin
        out_inst = NOP_INST;
        if (!fifo_empty) begin
            out_inst = fifo_head;
        end else if (bypass_hit) begin
            out_inst = imem_rdata;
        end
    end

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        deliver_pc_next  = deliver_pc_reg;
        outstanding_next = outstanding_reg;
        drop_next        = drop_reg;

        case ({grant, imem_rvalid})
            2'b10:   outstanding_next = outstanding_reg + CW'(1);
            2'b01:   outstanding_next = outstanding_reg - CW'(1);
            default: outstanding_next = outstanding_reg;
        endcase

        if (redirect_valid) begin
            fetch_pc_next   = redirect_pc;
            deliver_pc_next = redirect_pc;
            // Whatever is still in flight after this cycle belongs to the old path.
            drop_next       = outstanding_reg - rvalid_dec;
        end else begin
            if (grant) begin
                fetch_pc_next = pc_next(fetch_pc_reg);
            end
            if (transfer) begin
                deliver_pc_next = pc_next(deliver_pc_reg);
            end
            if (rsp_drop) begin
                drop_next = drop_reg - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_PC;
            deliver_pc_reg  <= RESET_PC;
            outstanding_reg <= '0;
            drop_reg        <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            deliver_pc_reg  <= deliver_pc_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INST_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (imem_rdata),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

endmodule
